// File: rtl/aes_pipe_scheduler_if.sv
// Handshake and round-control bundle between the requesters, the AES round
// datapath and the slot scheduler.
interface aes_pipe_scheduler_if;
    logic       req0_valid;
    logic       req0_dec;
    logic       req0_ready;
    logic       req1_valid;
    logic       req1_dec;
    logic       req1_ready;
    logic       core_valid;
    logic       core_load;
    logic       core_first;
    logic       core_final;
    logic       core_dec;
    logic [7:0] core_rcon;
    logic       out_valid;
    logic       out_id;
    logic       out_dec;
    logic       busy;

    // Requester / datapath side
    modport master (
        output req0_valid, req0_dec, req1_valid, req1_dec,
        input  req0_ready, req1_ready,
        input  core_valid, core_load, core_first, core_final, core_dec, core_rcon,
        input  out_valid, out_id, out_dec, busy
    );

    // Scheduler side
    modport slave (
        input  req0_valid, req0_dec, req1_valid, req1_dec,
        output req0_ready, req1_ready,
        output core_valid, core_load, core_first, core_final, core_dec, core_rcon,
        output out_valid, out_id, out_dec, busy
    );
endinterface

// File: rtl/aes_pipe_scheduler.sv
// Slot scheduler for the pipelined masked AES round datapath. Each of the
// SBOX_LATENCY slots holds one block context; the slot at the datapath entry
// rotates every cycle. Two requesters are arbitrated round-robin into free
// (or finishing) entry slots.
module aes_pipe_scheduler #(
    parameter int SBOX_LATENCY = 5,
    parameter int NUM_ROUNDS   = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_pipe_scheduler_if.slave  bus
);
    localparam int              PW       = $clog2(SBOX_LATENCY);
    localparam logic [PW-1:0]   PTR_LAST = PW'(SBOX_LATENCY - 1);
    localparam logic [3:0]      RND_LAST = 4'(NUM_ROUNDS);

    logic [PW-1:0]             ptr;
    logic [SBOX_LATENCY-1:0]   occ;
    logic [SBOX_LATENCY-1:0]   slot_dec;
    logic [SBOX_LATENCY-1:0]   slot_id;
    logic [3:0]                slot_round [SBOX_LATENCY];
    logic [7:0]                slot_rcon  [SBOX_LATENCY];
    logic                      prio;   // 0: requester 0 favoured, 1: requester 1 favoured

    logic       e_occ, finishing, available, feed;
    logic       grant0, grant1, accept, acc_dec;
    logic [3:0] e_round;
    logic [7:0] rcon_nx;

    // Encryption steps Rcon forward (xtime), decryption steps it backward.
    function automatic logic [7:0] rcon_next(input logic [7:0] r, input logic d);
        if (!d)
            return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
        else if (r[0])
            return ((r ^ 8'h1b) >> 1) | 8'h80;
        else
            return r >> 1;
    endfunction

    // Entry-slot decode, arbitration and per-cycle round controls.
    always_comb begin
        e_occ     = occ[ptr];
        e_round   = slot_round[ptr];
        finishing = e_occ && (e_round == RND_LAST);
        available = !e_occ || finishing;
        feed      = e_occ && !finishing;

        grant0  = available && bus.req0_valid && (!prio || !bus.req1_valid);
        grant1  = available && bus.req1_valid && (prio || !bus.req0_valid);
        accept  = grant0 || grant1;
        acc_dec = grant1 ? bus.req1_dec : bus.req0_dec;

        bus.req0_ready = grant0;
        bus.req1_ready = grant1;

        bus.core_valid = accept || feed;
        bus.core_load  = accept;
        bus.core_first = accept;
        bus.core_final = feed && (e_round == RND_LAST - 4'd1);
        bus.core_dec   = 1'b0;
        bus.core_rcon  = 8'h00;
        if (accept) begin
            bus.core_dec  = acc_dec;
            bus.core_rcon = acc_dec ? 8'h36 : 8'h01;
        end else if (feed) begin
            bus.core_dec  = slot_dec[ptr];
            bus.core_rcon = slot_rcon[ptr];
        end
        rcon_nx = rcon_next(bus.core_rcon, bus.core_dec);

        bus.out_valid = finishing;
        bus.out_id    = finishing && slot_id[ptr];
        bus.out_dec   = finishing && slot_dec[ptr];
        bus.busy      = |occ;
    end

    // Slot pointer rotation, slot context update and round-robin priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr  <= '0;
            occ  <= '0;
            prio <= 1'b0;
        end else begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
            if (accept) begin
                occ[ptr]        <= 1'b1;
                slot_round[ptr] <= 4'd1;
                slot_dec[ptr]   <= acc_dec;
                slot_id[ptr]    <= grant1;
                slot_rcon[ptr]  <= rcon_nx;
                prio            <= grant0;
            end else if (feed) begin
                slot_round[ptr] <= e_round + 4'd1;
                slot_rcon[ptr]  <= rcon_nx;
            end else if (finishing) begin
                occ[ptr] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_aes_pipe_scheduler.sv
// Directed bench for aes_pipe_scheduler: default depth 5 instance plus a
// depth 2 instance for the short-wrap case.
module tb_aes_pipe_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] enc_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [7:0] dec_tab [0:9] = '{8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                  8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    aes_pipe_scheduler_if bus5();
    aes_pipe_scheduler_if bus2();

    aes_pipe_scheduler #(.SBOX_LATENCY(5), .NUM_ROUNDS(10)) dut5 (
        .clk(clk), .rst(rst), .bus(bus5));
    aes_pipe_scheduler #(.SBOX_LATENCY(2), .NUM_ROUNDS(10)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus5.req0_valid = 1'b0; bus5.req0_dec = 1'b0;
        bus5.req1_valid = 1'b0; bus5.req1_dec = 1'b0;
        bus2.req0_valid = 1'b0; bus2.req0_dec = 1'b0;
        bus2.req1_valid = 1'b0; bus2.req1_dec = 1'b0;
    endtask

    // Leaves the bench 1 ns after the edge that ends reset: cycle 0.
    task automatic reset_pulse();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_single(input logic id, input logic dec);
        logic exp_pass;
        int   k;
        reset_pulse();
        chk("rst_busy",  bus5.busy, 8'd0);
        chk("rst_out",   bus5.out_valid, 8'd0);
        for (int c = 0; c < 53; c++) begin
            bus5.req0_valid = (id == 1'b0) && (c == 0);
            bus5.req1_valid = (id == 1'b1) && (c == 0);
            bus5.req0_dec   = dec;
            bus5.req1_dec   = dec;
            #1;
            exp_pass = (c % 5 == 0) && (c < 50);
            k = c / 5;
            chk("s_ready_own",   id ? bus5.req1_ready : bus5.req0_ready, 8'(c == 0));
            chk("s_ready_other", id ? bus5.req0_ready : bus5.req1_ready, 8'd0);
            chk("s_core_valid",  bus5.core_valid, 8'(exp_pass));
            chk("s_core_load",   bus5.core_load, 8'(c == 0));
            chk("s_core_first",  bus5.core_first, 8'(c == 0));
            chk("s_core_final",  bus5.core_final, 8'(c == 45));
            if (exp_pass) begin
                chk("s_rcon", bus5.core_rcon, dec ? dec_tab[k] : enc_tab[k]);
                chk("s_dec",  bus5.core_dec, 8'(dec));
            end else begin
                chk("s_rcon_idle", bus5.core_rcon, 8'h00);
            end
            chk("s_out_valid", bus5.out_valid, 8'(c == 50));
            if (c == 50) begin
                chk("s_out_id",  bus5.out_id, 8'(id));
                chk("s_out_dec", bus5.out_dec, 8'(dec));
            end
            chk("s_busy", bus5.busy, 8'((c >= 1) && (c <= 50)));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        idle_inputs();
        repeat (2) @(posedge clk);

        // Single encryption block from requester 0.
        run_single(1'b0, 1'b0);
        // Single decryption block from requester 1 while requester 0 holds priority.
        run_single(1'b1, 1'b1);

        // Both requesters valid continuously: round-robin fill, then refill on finish.
        reset_pulse();
        bus5.req0_valid = 1'b1; bus5.req1_valid = 1'b1;
        for (int c = 0; c < 55; c++) begin
            #1;
            if (c < 5) begin
                chk("b_ready0", bus5.req0_ready, 8'(c % 2 == 0));
                chk("b_ready1", bus5.req1_ready, 8'(c % 2 == 1));
                chk("b_out_early", bus5.out_valid, 8'd0);
            end else if (c < 50) begin
                chk("b_ready0_full", bus5.req0_ready, 8'd0);
                chk("b_ready1_full", bus5.req1_ready, 8'd0);
                chk("b_out_mid", bus5.out_valid, 8'd0);
            end else begin
                chk("b_out_valid", bus5.out_valid, 8'd1);
                chk("b_out_id",    bus5.out_id, 8'(c % 2));
                chk("b_ready0_re", bus5.req0_ready, 8'(c % 2 == 1));
                chk("b_ready1_re", bus5.req1_ready, 8'(c % 2 == 0));
                chk("b_load_re",   bus5.core_load, 8'd1);
            end
            @(posedge clk); #1;
        end

        // Reset while three blocks are in flight.
        reset_pulse();
        for (int c = 0; c < 73; c++) begin
            bus5.req0_valid = (c < 3) || (c == 21);
            bus5.req0_dec   = 1'b0;
            rst = (c == 20);
            #1;
            if (c < 3 || c == 21)
                chk("r_ready0", bus5.req0_ready, 8'd1);
            chk("r_out_valid", bus5.out_valid, 8'(c == 71));
            chk("r_busy", bus5.busy, 8'((c >= 1 && c <= 20) || (c >= 22 && c <= 71)));
            if (c == 26) begin
                chk("r_ptr_valid", bus5.core_valid, 8'd1);
                chk("r_ptr_rcon",  bus5.core_rcon, 8'h02);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;

        // Depth-2 instance: enc and dec contexts interleave.
        reset_pulse();
        for (int c = 0; c < 23; c++) begin
            bus2.req0_valid = (c == 0); bus2.req0_dec = 1'b0;
            bus2.req1_valid = (c == 1); bus2.req1_dec = 1'b1;
            #1;
            if (c == 0) chk("w_ready0", bus2.req0_ready, 8'd1);
            if (c == 1) chk("w_ready1", bus2.req1_ready, 8'd1);
            if (c < 20) begin
                chk("w_core_valid", bus2.core_valid, 8'd1);
                chk("w_rcon", bus2.core_rcon, (c % 2 == 1) ? dec_tab[c / 2] : enc_tab[c / 2]);
                chk("w_dec",  bus2.core_dec, 8'(c % 2));
                chk("w_final", bus2.core_final, 8'(c >= 18));
            end
            chk("w_out_valid", bus2.out_valid, 8'(c == 20 || c == 21));
            if (c == 20 || c == 21) begin
                chk("w_out_id",  bus2.out_id, 8'(c - 20));
                chk("w_out_dec", bus2.out_dec, 8'(c - 20));
            end
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
